// File: rtl/sdram_wt_cache_if.sv
// CPU-side and controller-side handshake bundle for the write-through cache.
// "slave" is the cache's view; "master" is the CPU plus SDRAM controller side.
interface sdram_wt_cache_if #(
  parameter int ADDR_WIDTH = 25
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_din;
  logic [3:0]            cpu_wmask;
  logic                  cpu_valid;
  logic [31:0]           cpu_dout;
  logic                  cpu_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_din;
  logic [3:0]            mem_wmask;
  logic                  mem_valid;
  logic [31:0]           mem_dout;
  logic                  mem_ready;

  modport slave (
    input  cpu_addr, cpu_din, cpu_wmask, cpu_valid, mem_dout, mem_ready,
    output cpu_dout, cpu_ready, mem_addr, mem_din, mem_wmask, mem_valid
  );

  modport master (
    output cpu_addr, cpu_din, cpu_wmask, cpu_valid, mem_dout, mem_ready,
    input  cpu_dout, cpu_ready, mem_addr, mem_din, mem_wmask, mem_valid
  );
endinterface

// File: rtl/sdram_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of the
// SDRAM controller. Read hits complete in two cycles; misses/writes pass through.
module sdram_wt_cache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_WIDTH = 25
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  sdram_wt_cache_if.slave    bus,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOOKUP    = 2'd1;
  localparam logic [1:0] S_MEM_READ  = 2'd2;
  localparam logic [1:0] S_MEM_WRITE = 2'd3;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  is_write;
  logic                  lookup_hit;
  logic                  fill_we, merge_we;
  logic                  addr_lsb_unused;

  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];
  logic [TAG_W-1:0]      rd_tag_q;
  logic [31:0]           rd_data_q;

  logic [LINES-1:0]      valid_q;
  logic                  flush_pend_q;
  logic                  hit_q;
  logic                  cpu_ready_q;
  logic [31:0]           cpu_dout_q;
  logic                  mem_valid_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_din_q;
  logic [3:0]            mem_wmask_q;
  logic [31:0]           hit_count_q, miss_count_q;

  assign idx             = bus.cpu_addr[INDEX_BITS+1:2];
  assign tag             = bus.cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2];
  assign addr_lsb_unused = ^bus.cpu_addr[1:0];
  assign is_write        = |bus.cpu_wmask;
  assign lookup_hit      = valid_q[idx] && (rd_tag_q == tag);
  assign fill_we         = (state_q == S_MEM_READ) && bus.mem_ready;
  assign merge_we        = (state_q == S_MEM_WRITE) && bus.mem_ready && hit_q;

  assign bus.cpu_ready = cpu_ready_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign hit_count     = hit_count_q;
  assign miss_count    = miss_count_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!flush_pend_q && bus.cpu_valid && !cpu_ready_q) state_d = S_LOOKUP;
      S_LOOKUP:    state_d = is_write ? S_MEM_WRITE : (lookup_hit ? S_IDLE : S_MEM_READ);
      S_MEM_READ:  if (bus.mem_ready) state_d = S_IDLE;
      S_MEM_WRITE: if (bus.mem_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Tag/data RAM: read issued from IDLE, written on fill or write-hit merge.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      rd_tag_q  <= tag_mem[idx];
      rd_data_q <= data_mem[idx];
    end
    if (fill_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= bus.mem_dout;
    end else if (merge_we) begin
      data_mem[idx] <= merge_bytes(rd_data_q, bus.cpu_din, bus.cpu_wmask);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= 1'b0;
      cpu_ready_q  <= 1'b0;
      cpu_dout_q   <= '0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_wmask_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cpu_ready_q  <= 1'b0;
      flush_pend_q <= flush_pend_q | flush;
      case (state_q)
        S_IDLE: begin
          if (flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= flush;
          end
        end
        S_LOOKUP: begin
          hit_q <= lookup_hit;
          if (is_write) begin
            mem_valid_q <= 1'b1;
            mem_wmask_q <= bus.cpu_wmask;
            mem_din_q   <= bus.cpu_din;
            mem_addr_q  <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          end else if (lookup_hit) begin
            cpu_dout_q  <= rd_data_q;
            cpu_ready_q <= 1'b1;
            hit_count_q <= hit_count_q + 32'd1;
          end else begin
            miss_count_q <= miss_count_q + 32'd1;
            mem_valid_q  <= 1'b1;
            mem_wmask_q  <= 4'b0000;
            mem_addr_q   <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        // A fill landing while a flush is pending is invalidated on the next IDLE.
        S_MEM_READ: begin
          if (bus.mem_ready) begin
            valid_q[idx] <= 1'b1;
            cpu_dout_q   <= bus.mem_dout;
            cpu_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
          end
        end
        S_MEM_WRITE: begin
          if (bus.mem_ready) begin
            cpu_ready_q <= 1'b1;
            mem_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_wt_cache.sv
// Directed bench for sdram_wt_cache with a small fixed-latency SDRAM model.
module tb_sdram_wt_cache;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_count, miss_count;

  sdram_wt_cache_if #(.ADDR_WIDTH(25)) bus ();

  sdram_wt_cache #(.INDEX_BITS(8), .ADDR_WIDTH(25)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] model [int];
  int          acc = 0;
  int          lat_cnt = 0;
  int          stab_err = 0;
  logic [24:0] last_addr;
  logic [3:0]  last_wmask;
  logic [31:0] last_din;

  // SDRAM model: answers each access three falling edges after mem_valid rises.
  always @(negedge clk) begin
    logic [31:0] w;
    if (!resetn || !bus.mem_valid || bus.mem_ready) begin
      bus.mem_ready = 1'b0;
      lat_cnt = 0;
    end else begin
      if (lat_cnt == 0) begin
        last_addr  = bus.mem_addr;
        last_wmask = bus.mem_wmask;
        last_din   = bus.mem_din;
      end else if (bus.mem_addr !== last_addr || bus.mem_wmask !== last_wmask ||
                   bus.mem_din !== last_din) begin
        stab_err++;
      end
      lat_cnt++;
      if (lat_cnt == 3) begin
        acc++;
        w = model.exists(int'(bus.mem_addr)) ? model[int'(bus.mem_addr)] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (bus.mem_wmask[b]) w[8*b +: 8] = bus.mem_din[8*b +: 8];
        if (bus.mem_wmask != 4'b0000) model[int'(bus.mem_addr)] = w;
        bus.mem_dout  = w;
        bus.mem_ready = 1'b1;
      end
    end
  end

  task automatic do_req(input logic [24:0] a, input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rdata, output int cyc);
    logic done;
    @(negedge clk);
    @(negedge clk);
    bus.cpu_addr  = a;
    bus.cpu_din   = d;
    bus.cpu_wmask = m;
    bus.cpu_valid = 1'b1;
    cyc = 0;
    done = 1'b0;
    rdata = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.cpu_ready) begin
        rdata = bus.cpu_dout;
        done = 1'b1;
        break;
      end
    end
    bus.cpu_valid = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout addr=%h got_ready=%b want=1", a, done);
    end
  endtask

  task automatic test_reset();
    bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_wmask = '0; bus.cpu_valid = 1'b0;
    bus.mem_dout = '0; bus.mem_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready got=%b want=0", bus.cpu_ready); end
    n_cmp++; if (bus.cpu_dout !== 32'h0) begin n_fail++; $display("FAIL rst_cpu_dout got=%h want=0", bus.cpu_dout); end
    n_cmp++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid got=%b want=0", bus.mem_valid); end
    n_cmp++; if ({bus.mem_addr, bus.mem_din, bus.mem_wmask} !== 61'h0) begin n_fail++; $display("FAIL rst_mem_bus got=%h/%h/%h want=0", bus.mem_addr, bus.mem_din, bus.mem_wmask); end
    n_cmp++; if ({hit_count, miss_count} !== 64'h0) begin n_fail++; $display("FAIL rst_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
    resetn = 1'b1;
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] rd; int cyc; int a0;
    a0 = acc;
    do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL miss_data got=%h want=deadbeef", rd); end
    n_cmp++; if (acc - a0 !== 1) begin n_fail++; $display("FAIL miss_accesses got=%0d want=1", acc - a0); end
    n_cmp++; if (last_addr !== 25'h100 || last_wmask !== 4'b0000) begin n_fail++; $display("FAIL miss_mem_req got=%h/%b want=100/0000", last_addr, last_wmask); end
    n_cmp++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL miss_count1 got=%0d want=1", miss_count); end
    a0 = acc;
    do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (cyc !== 2) begin n_fail++; $display("FAIL hit_latency got=%0d want=2", cyc); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_data got=%h want=deadbeef", rd); end
    n_cmp++; if (acc - a0 !== 0) begin n_fail++; $display("FAIL hit_accesses got=%0d want=0", acc - a0); end
    n_cmp++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL hit_count1 got=%0d want=1", hit_count); end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int cyc;
    do_req(25'h100, 32'h12345678, 4'b0011, rd, cyc);
    n_cmp++; if (last_wmask !== 4'b0011 || last_addr !== 25'h100 || last_din !== 32'h12345678) begin n_fail++; $display("FAIL wr_fwd got=%h/%b/%h want=100/0011/12345678", last_addr, last_wmask, last_din); end
    n_cmp++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin n_fail++; $display("FAIL wr_counters got=%0d/%0d want=1/1", hit_count, miss_count); end
    do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (rd !== 32'hDEAD5678 || cyc !== 2) begin n_fail++; $display("FAIL wr_merge_hit got=%h/%0d want=dead5678/2", rd, cyc); end
    n_cmp++; if (hit_count !== 32'd2) begin n_fail++; $display("FAIL hit_count2 got=%0d want=2", hit_count); end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int cyc;
    do_req(25'h200, 32'hA5A5A5A5, 4'b1111, rd, cyc);
    do_req(25'h200, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (miss_count !== 32'd2) begin n_fail++; $display("FAIL no_alloc_miss got=%0d want=2", miss_count); end
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL no_alloc_data got=%h want=a5a5a5a5", rd); end
  endtask

  task automatic test_alias();
    logic [31:0] rd; int cyc;
    do_req(25'h500, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL alias_a got=%h want=cafef00d", rd); end
    do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (rd !== 32'hDEAD5678) begin n_fail++; $display("FAIL alias_b got=%h want=dead5678", rd); end
    do_req(25'h500, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (miss_count !== 32'd5 || hit_count !== 32'd2) begin n_fail++; $display("FAIL alias_counts got=%0d/%0d want=5/2", miss_count, hit_count); end
  endtask

  task automatic test_flush_inflight();
    logic [31:0] rd; int cyc; logic seen;
    seen = 1'b0;
    fork
      do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
      begin
        for (int k = 0; k < 50; k++) begin
          @(posedge clk); #1;
          if (bus.mem_valid) begin seen = 1'b1; break; end
        end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL flush_wait_mem got=%b want=1", seen); end
    n_cmp++; if (rd !== 32'hDEAD5678) begin n_fail++; $display("FAIL flush_fill_data got=%h want=dead5678", rd); end
    do_req(25'h100, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (miss_count !== 32'd7) begin n_fail++; $display("FAIL flush_refetch got=%0d want=7", miss_count); end
    do_req(25'h200, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (miss_count !== 32'd8 || rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL flush_other got=%0d/%h want=8/a5a5a5a5", miss_count, rd); end
  endtask

  task automatic test_back_to_back();
    int p1, p2; logic [31:0] rd;
    p1 = -1; p2 = -1; rd = 32'h0;
    @(negedge clk); @(negedge clk);
    bus.cpu_addr = 25'h200; bus.cpu_wmask = 4'b0000; bus.cpu_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.cpu_ready) begin
        if (p1 < 0) p1 = i;
        else begin p2 = i; rd = bus.cpu_dout; break; end
      end
    end
    bus.cpu_valid = 1'b0;
    n_cmp++; if (p2 - p1 !== 3 || p1 < 0) begin n_fail++; $display("FAIL b2b_spacing got=%0d want=3", p2 - p1); end
    n_cmp++; if (hit_count !== 32'd4 || rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_hits got=%0d/%h want=4/a5a5a5a5", hit_count, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int cyc; logic seen; int a0;
    seen = 1'b0;
    @(negedge clk); @(negedge clk);
    bus.cpu_addr = 25'h500; bus.cpu_wmask = 4'b0000; bus.cpu_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.mem_valid) begin seen = 1'b1; break; end
    end
    n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rstmid_mem_valid_rise got=%b want=1", seen); end
    @(negedge clk); #1;
    resetn = 1'b0;
    #1;
    n_cmp++; if (bus.mem_valid !== 1'b0 || bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_handshake got=%b/%b want=0/0", bus.mem_valid, bus.cpu_ready); end
    n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
    bus.cpu_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    a0 = acc;
    do_req(25'h200, 32'h0, 4'b0000, rd, cyc);
    n_cmp++; if (miss_count !== 32'd1 || acc - a0 !== 1) begin n_fail++; $display("FAIL rstmid_cold got=%0d/%0d want=1/1", miss_count, acc - a0); end
    n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rstmid_data got=%h want=a5a5a5a5", rd); end
  endtask

  initial begin
    model[32'h100] = 32'hDEADBEEF;
    model[32'h500] = 32'hCAFEF00D;
    model[32'h200] = 32'h11112222;
    test_reset();
    test_read_miss_hit();
    test_write_hit();
    test_write_miss();
    test_alias();
    test_flush_inflight();
    test_back_to_back();
    test_reset_mid();
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL mem_bus_stable got=%0d want=0", stab_err); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sdram_wt_cache.md
# sdram_wt_cache

Direct-mapped, write-through, no-write-allocate word cache placed between the CPU memory port and the `mt48lc16m16a2_ctrl` SDRAM controller. Read hits return in two cycles, so most fetches avoid the controller's activate/CAS/precharge round trip. Misses and all writes are forwarded unchanged over the controller's valid/ready interface. A flush input invalidates the whole cache after external agents (DMA, loader) write SDRAM behind it.

## Interface
- `INDEX_BITS`, default 8: log2 of line count (256 lines); one 32-bit word per line.
- `ADDR_WIDTH`, default 25: byte-address width (32 MB SDRAM).
- `clk` in, 1: single clock, same clock as the SDRAM controller.
- `resetn` in, 1: reset is asynchronous and active-low.
- `cpu_addr` in, ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `cpu_din` in, 32: write data.
- `cpu_wmask` in, 4: byte enables; 0 means read.
- `cpu_valid` in, 1: request; held with stable inputs until `cpu_ready`.
- `cpu_dout` out, 32: read data, valid while `cpu_ready`=1.
- `cpu_ready` out, 1: one-cycle completion pulse.
- `flush` in, 1: single-cycle request to invalidate all lines.
- `mem_addr` out, ADDR_WIDTH: to controller `addr`, word aligned ([1:0]=0).
- `mem_din` out, 32: to controller `din`.
- `mem_wmask` out, 4: to controller `wmask`.
- `mem_valid` out, 1: to controller `valid`.
- `mem_dout` in, 32: from controller `dout`.
- `mem_ready` in, 1: from controller `ready`, one-cycle pulse.
- `hit_count` out, 32: read hits, wraps at 2^32.
- `miss_count` out, 32: read misses, wraps at 2^32.

## Operation
- Address split:
  - index = `cpu_addr[INDEX_BITS+1:2]`
  - tag = `cpu_addr[ADDR_WIDTH-1:INDEX_BITS+2]`
- Storage:
  - tag and data arrays are synchronous-read RAM with no reset.
  - the valid vector is flops, cleared by reset.
- States: IDLE, LOOKUP, MEM_READ, MEM_WRITE.
- **IDLE**
  - Pending flush has priority: clear all valid bits, clear the pending flag, stay in IDLE.
  - Otherwise, if `cpu_valid && !cpu_ready`: issue the RAM read at index and go to LOOKUP.
- **LOOKUP**
  - hit = valid[index] && stored tag == tag.
  - Read hit: `cpu_dout`<=data, `cpu_ready`<=1, `hit_count`++, go to IDLE.
  - Read miss: `miss_count`++; `mem_valid`<=1, `mem_wmask`<=0, `mem_addr`<={`cpu_addr`[ADDR_WIDTH-1:2],2'b00}; go to MEM_READ.
  - Write (hit or miss): `mem_valid`<=1 with `mem_wmask`=`cpu_wmask`, `mem_din`=`cpu_din`, aligned `mem_addr`; go to MEM_WRITE.
- **MEM_READ**
  - Wait for `mem_ready`.
  - On `mem_ready`: write tag and data, set valid[index], `cpu_dout`<=`mem_dout`, `cpu_ready`<=1, `mem_valid`<=0, go to IDLE.
- **MEM_WRITE**
  - Wait for `mem_ready`.
  - On `mem_ready`: if the LOOKUP result was a hit, merge `cpu_din` bytes selected by `cpu_wmask` into the stored data word (valid stays set). Then `cpu_ready`<=1, `mem_valid`<=0, go to IDLE.
  - A write miss never allocates a line.
- **Flush**
  - `flush` is sampled every cycle and sets the pending flag.
  - The flag is serviced only in IDLE, so an in-flight transaction completes first.
  - If a fill completes and a flush is pending, the fill's valid bit is cleared by the flush on the next IDLE cycle.
- Writes do not change either counter.

## Timing
- Reset values:
  - `cpu_ready`=0, `cpu_dout`=0, `mem_valid`=0, `mem_addr`=0, `mem_din`=0, `mem_wmask`=0.
  - `hit_count`=0, `miss_count`=0; all valid bits=0; pending flush=0; state=IDLE.
- Reset mid-transaction: all of the above apply immediately (asynchronously). `resetn` is shared with the controller, so no orphaned SDRAM access survives.
- Read hit: `cpu_valid` sampled in IDLE at cycle 0, LOOKUP at cycle 1, `cpu_ready` high at cycle 2.
- Miss or write: `mem_valid` rises at cycle 2 and stays high until the cycle `mem_ready` is sampled. It is low in the cycle after, so the controller does not start a second access. `cpu_ready` rises in that same cycle.
- `mem_addr`, `mem_din` and `mem_wmask` are stable for the whole time `mem_valid` is high.
- `cpu_ready` is high for exactly one cycle. Back-to-back requests: IDLE ignores `cpu_valid` while `cpu_ready`=1, so the minimum spacing is 3 cycles between read hits.
- Counter wrap: 0xFFFFFFFF + 1 -> 0.

## Test plan
- Reset, then read 0x0000100 with the SDRAM model holding 0xDEADBEEF -> one `mem_valid` access with `mem_wmask`=0 and `mem_addr`=0x0000100; `cpu_dout`=0xDEADBEEF; `miss_count`=1. Repeat the read -> `cpu_ready` 2 cycles after valid, no `mem_valid`, `hit_count`=1.
- Write 0x0000100 with `cpu_wmask`=4'b0011, `cpu_din`=0x12345678 after it is cached -> `mem_wmask`=0011 forwarded; a following read hits and returns 0xDEAD5678.
- Write miss to 0x0000200, then read 0x0000200 -> the read is a miss (`miss_count`++), proving no-write-allocate.
- Alias conflict: read 0x0000100, then 0x0000500 (same index with INDEX_BITS=8, different tag), then 0x0000100 -> three misses.
- Assert `flush` while MEM_READ is waiting -> the read completes normally; the next read of the same address misses.
- Deassert `resetn` while `mem_valid`=1 -> `mem_valid`, `cpu_ready` and counters are 0 in the same cycle; after release the first read of a previously cached address misses.
